mem_port_arbiter: RTL and testbench

//  Shares one 32-bit memory port between two requesters: 0 = instruction fetch, 1 = data access.

---
 rtl/mem_port_arbiter_pkg.sv | 14 +
 rtl/mem_port_arbiter_mux.sv | 18 +
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM state encoding and
// the datapath / wait-counter widths.
package mem_port_arbiter_pkg;

    localparam int MEM_ARB_WORD_W = 32;
    localparam int MEM_ARB_CNT_W  = 16;

    typedef enum logic [1:0] {
        MEM_ARB_IDLE = 2'd0,
        MEM_ARB_BUSY = 2'd1,
        MEM_ARB_RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_mux.sv
// 32-bit two-input multiplexer used for the address and write-data paths.
// Ports:
//   sel  in   1   0 selects d0, 1 selects d1
//   d0   in   32  input 0
//   d1   in   32  input 1
//   y    out  32  selected value
module mux2to1_32bit
    import mem_port_arbiter_pkg::*;
(
    input  logic                      sel,
    input  logic [MEM_ARB_WORD_W-1:0] d0,
    input  logic [MEM_ARB_WORD_W-1:0] d1,
    output logic [MEM_ARB_WORD_W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one 32-bit memory port between instruction fetch (requester 0)
// and data access (requester 1). One transaction at a time: the winner's
// address/wdata/we are latched, the owner is held until completion, and the
// read data (or a timeout error) is returned with a one-cycle done pulse.
//
// Build option: define MEM_ARB_FIXED_PRIO_EN to make requester 1 always win
// ties (no round-robin; fetch may starve). Default is round-robin.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   reqN_valid/addr/wdata/we     request from requester N (N = 0, 1)
//   reqN_ready                   request N accepted this cycle
//   reqN_done                    one-cycle pulse, request N complete
//   rsp_rdata, rsp_err           response data / timeout flag, valid with done
//   mem_req/addr/wdata/we        memory-side request, held for the transaction
//   mem_ready, mem_rdata         memory completion and read data
//   owner                        current/last granted requester
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | pick a winner, accept one request
// BUSY  | memory access in flight, count wait cycles until ready/timeout
// RESP  | pulse done for the owner, update round-robin state
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int WAIT_LIMIT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic [DATA_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic                  req0_we,
    output logic                  req0_ready,
    output logic                  req0_done,
    input  logic                  req1_valid,
    input  logic [DATA_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic                  req1_we,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  mem_req,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    input  logic                  mem_ready,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner
);

    localparam logic [MEM_ARB_CNT_W-1:0] LIMIT_M1 = MEM_ARB_CNT_W'(WAIT_LIMIT - 1);

    arb_state_t                state;
    arb_state_t                state_nxt;
    logic                      winner;
    logic                      transfer;
    logic                      timeout;
    logic [MEM_ARB_CNT_W-1:0]  wait_cnt;
    logic [DATA_WIDTH-1:0]     addr_sel;
    logic [DATA_WIDTH-1:0]     wdata_sel;

`ifndef MEM_ARB_FIXED_PRIO_EN
    logic                      last_grant;
`endif

    always_comb begin
        winner = req1_valid;
        if (req0_valid && req1_valid) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
            winner = 1'b1;
`else
            winner = ~last_grant;
`endif
        end
    end

    assign transfer = (state == MEM_ARB_IDLE) && (req0_valid || req1_valid);
    assign timeout  = (wait_cnt == LIMIT_M1);

    mux2to1_32bit u_addr_mux (
        .sel (winner),
        .d0  (req0_addr),
        .d1  (req1_addr),
        .y   (addr_sel)
    );

    mux2to1_32bit u_wdata_mux (
        .sel (winner),
        .d0  (req0_wdata),
        .d1  (req1_wdata),
        .y   (wdata_sel)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MEM_ARB_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MEM_ARB_IDLE: if (transfer)             state_nxt = MEM_ARB_BUSY;
            MEM_ARB_BUSY: if (mem_ready || timeout) state_nxt = MEM_ARB_RESP;
            MEM_ARB_RESP:                           state_nxt = MEM_ARB_IDLE;
            default:                                state_nxt = MEM_ARB_IDLE;
        endcase
    end

    // Ready is gated with valid so nothing reads as accepted when idle.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        req0_done  = 1'b0;
        req1_done  = 1'b0;
        mem_req    = 1'b0;
        case (state)
            MEM_ARB_IDLE: begin
                req0_ready = req0_valid && !winner;
                req1_ready = req1_valid &&  winner;
            end
            MEM_ARB_BUSY: mem_req = 1'b1;
            MEM_ARB_RESP: begin
                req0_done = !owner;
                req1_done =  owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            owner     <= 1'b0;
            wait_cnt  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                MEM_ARB_IDLE: if (transfer) begin
                    mem_addr  <= addr_sel;
                    mem_wdata <= wdata_sel;
                    mem_we    <= winner ? req1_we : req0_we;
                    owner     <= winner;
                    wait_cnt  <= '0;
                end
                MEM_ARB_BUSY: begin
                    // mem_ready takes priority over a coincident timeout.
                    if (mem_ready) begin
                        rsp_rdata <= mem_we ? '0 : mem_rdata;
                        rsp_err   <= 1'b0;
                    end else if (timeout) begin
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b1;
                    end else if (wait_cnt != '1) begin
                        wait_cnt  <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifndef MEM_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       last_grant <= 1'b1;
        else if (state == MEM_ARB_RESP) last_grant <= owner;
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;

    logic        req0_valid, req0_we, req0_ready, req0_done;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_we, req1_ready, req1_done;
    logic [31:0] req1_addr, req1_wdata;
    logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        rsp_err, mem_req, mem_we, mem_ready, owner;

    logic        b_req0_valid, b_req0_we, b_req0_ready, b_req0_done;
    logic [31:0] b_req0_addr, b_req0_wdata;
    logic        b_req1_valid, b_req1_we, b_req1_ready, b_req1_done;
    logic [31:0] b_req1_addr, b_req1_wdata;
    logic [31:0] b_rsp_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_rsp_err, b_mem_req, b_mem_we, b_mem_ready, b_owner;

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(32), .WAIT_LIMIT(255)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_we(req0_we), .req0_ready(req0_ready), .req0_done(req0_done),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_we(req1_we), .req1_ready(req1_ready), .req1_done(req1_done),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_port_arbiter #(.DATA_WIDTH(32), .WAIT_LIMIT(4)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
        .req0_we(b_req0_we), .req0_ready(b_req0_ready), .req0_done(b_req0_done),
        .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
        .req1_we(b_req1_we), .req1_ready(b_req1_ready), .req1_done(b_req1_done),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we),
        .mem_ready(b_mem_ready), .mem_rdata(b_mem_rdata), .owner(b_owner)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic        lg;
    logic        exp_w;
    int          cnt;

    initial begin
        rst = 1'b1;
        {req0_valid, req0_we, req1_valid, req1_we, mem_ready} = '0;
        {req0_addr, req0_wdata, req1_addr, req1_wdata, mem_rdata} = '0;
        {b_req0_valid, b_req0_we, b_req1_valid, b_req1_we, b_mem_ready} = '0;
        {b_req0_addr, b_req0_wdata, b_req1_addr, b_req1_wdata, b_mem_rdata} = '0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_owner", 32'(owner), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
        check("rst_done", 32'({req0_done, req1_done}), 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", 32'(rsp_err), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        step();

        // 1: single read from requester 0, minimum latency
        req0_valid = 1'b1; req0_addr = 32'h100; req0_we = 1'b0;
        #1;
        check("t1_ready0", 32'(req0_ready), 32'd1);
        check("t1_ready1", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        #1;
        check("t1_mem_req", 32'(mem_req), 32'd1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_owner", 32'(owner), 32'd0);
        step();
        mem_ready = 1'b0;
        check("t1_done0", 32'(req0_done), 32'd1);
        check("t1_done1", 32'(req1_done), 32'd0);
        check("t1_rdata", rsp_rdata, 32'hDEADBEEF);
        check("t1_err", 32'(rsp_err), 32'd0);
        check("t1_mem_req_resp", 32'(mem_req), 32'd0);
        step();
        check("t1_done_pulse", 32'(req0_done), 32'd0);

        // 2: both valid over four transactions
        lg = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
            exp_w = 1'b1;
`else
            exp_w = ~lg;
`endif
            check("t2_ready0", 32'(req0_ready), 32'(!exp_w));
            check("t2_ready1", 32'(req1_ready), 32'(exp_w));
            step();
            mem_ready = 1'b1; mem_rdata = 32'h1000 + 32'(i);
            #1;
            check("t2_owner", 32'(owner), 32'(exp_w));
            check("t2_mem_addr", mem_addr, exp_w ? 32'h20 : 32'h10);
            step();
            mem_ready = 1'b0;
            check("t2_done", 32'({req1_done, req0_done}), exp_w ? 32'd2 : 32'd1);
            check("t2_rdata", rsp_rdata, 32'h1000 + 32'(i));
            check("t2_no_accept_resp", 32'({req0_ready, req1_ready}), 32'd0);
            lg = exp_w;
            step();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // 3: requester 1 write with five wait cycles
        req1_valid = 1'b1; req1_addr = 32'h40; req1_wdata = 32'h3C3C3C3C; req1_we = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        #1;
        check("t3_ready1", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0; req1_wdata = 32'h0; req1_we = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("t3_wdata", mem_wdata, 32'h3C3C3C3C);
            check("t3_mem_req", 32'(mem_req), 32'd1);
            step();
        end
        mem_ready = 1'b1;
        check("t3_we", 32'(mem_we), 32'd1);
        check("t3_addr", mem_addr, 32'h40);
        step();
        mem_ready = 1'b0;
        check("t3_done1", 32'(req1_done), 32'd1);
        check("t3_rdata", rsp_rdata, 32'd0);
        check("t3_err", 32'(rsp_err), 32'd0);
        step();

        // 6: mem_ready while idle, valid dropped during BUSY
        mem_ready = 1'b1; mem_rdata = 32'h55;
        step();
        check("t6_idle_mem_req", 32'(mem_req), 32'd0);
        check("t6_idle_done", 32'({req0_done, req1_done}), 32'd0);
        check("t6_idle_rdata", rsp_rdata, 32'd0);
        mem_ready = 1'b0;
        req0_valid = 1'b1; req0_addr = 32'h200; req0_we = 1'b0;
        #1;
        check("t6_ready0", 32'(req0_ready), 32'd1);
        step();
        req0_valid = 1'b0; req0_addr = 32'h999;
        step();
        check("t6_mem_addr", mem_addr, 32'h200);
        check("t6_mem_req", 32'(mem_req), 32'd1);
        mem_ready = 1'b1; mem_rdata = 32'h12345678;
        step();
        mem_ready = 1'b0;
        check("t6_done0", 32'(req0_done), 32'd1);
        check("t6_rdata", rsp_rdata, 32'h12345678);
        step();

        // 4 (WAIT_LIMIT=4 instance): ready coinciding with limit, then timeout
        b_req0_valid = 1'b1; b_req0_addr = 32'h80;
        #1;
        check("t4_ready_a", 32'(b_req0_ready), 32'd1);
        step();
        b_req0_valid = 1'b0;
        repeat (3) step();
        b_mem_ready = 1'b1; b_mem_rdata = 32'hA5A5A5A5;
        step();
        b_mem_ready = 1'b0;
        check("t4_coinc_done", 32'(b_req0_done), 32'd1);
        check("t4_coinc_err", 32'(b_rsp_err), 32'd0);
        check("t4_coinc_rdata", b_rsp_rdata, 32'hA5A5A5A5);
        step();

        b_req0_valid = 1'b1; b_req0_addr = 32'h84;
        #1;
        step();
        b_req0_valid = 1'b0;
        cnt = 0;
        while (b_mem_req && cnt < 20) begin
            cnt++;
            step();
        end
        check("t4_busy_cycles", 32'(cnt), 32'd4);
        check("t4_to_done", 32'(b_req0_done), 32'd1);
        check("t4_to_err", 32'(b_rsp_err), 32'd1);
        check("t4_to_rdata", b_rsp_rdata, 32'd0);
        step();

        b_req0_valid = 1'b1; b_req0_addr = 32'h88;
        #1;
        check("t4_next_ready", 32'(b_req0_ready), 32'd1);
        step();
        b_req0_valid = 1'b0; b_mem_ready = 1'b1; b_mem_rdata = 32'h77;
        #1;
        check("t4_next_addr", b_mem_addr, 32'h88);
        step();
        b_mem_ready = 1'b0;
        check("t4_next_done", 32'(b_req0_done), 32'd1);
        check("t4_next_err", 32'(b_rsp_err), 32'd0);
        check("t4_next_rdata", b_rsp_rdata, 32'h77);
        step();

        // 5: reset during BUSY
        req1_valid = 1'b1; req1_addr = 32'h44; req1_we = 1'b0;
        #1;
        step();
        req1_valid = 1'b0;
        check("t5_owner_busy", 32'(owner), 32'd1);
        check("t5_mem_req_busy", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_mem_req_rst", 32'(mem_req), 32'd0);
        check("t5_owner_rst", 32'(owner), 32'd0);
        check("t5_done_rst", 32'({req0_done, req1_done}), 32'd0);
        step();
        rst = 1'b0;
        step();
        check("t5_done_after", 32'({req0_done, req1_done}), 32'd0);
        check("t5_mem_req_after", 32'(mem_req), 32'd0);
        req0_valid = 1'b1; req0_addr = 32'h10;
        req1_valid = 1'b1; req1_addr = 32'h20;
        #1;
`ifdef MEM_ARB_FIXED_PRIO_EN
        exp_w = 1'b1;
`else
        exp_w = 1'b0;
`endif
        check("t5_tie_ready0", 32'(req0_ready), 32'(!exp_w));
        check("t5_tie_ready1", 32'(req1_ready), 32'(exp_w));
        step();
        req0_valid = 1'b0; req1_valid = 1'b0;
        mem_ready = 1'b1; mem_rdata = 32'hCAFE0001;
        step();
        mem_ready = 1'b0;
        check("t5_done", 32'({req1_done, req0_done}), exp_w ? 32'd2 : 32'd1);
        check("t5_rdata", rsp_rdata, 32'hCAFE0001);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

endmodule
